// File: rtl/pll_lock_monitor.sv
`timescale 1ns/1ps
// pll_lock_monitor
//   Supervises NUM_CH PLL lock indications in the clk_tb domain. Each lock
//   input is synchronised and then tracked by its own state machine. The
//   machine enforces an acquisition timeout, detects loss of lock, and allows
//   a bounded number of relocks before latching a failure.
//
// Ports
//   clk_tb       monitor clock
//   rst_n        asynchronous active-low reset
//   arm          1-cycle pulse: restart supervision of every enabled channel
//   clear        1-cycle pulse: zero results_cnt (drops that cycle's events)
//   ch_en        per-channel enable, static between arms
//   pll_lock     asynchronous lock indications
//   ch_locked    channel is in LOCKED
//   ch_fail      channel is in FAIL (sticky until arm or reset)
//   err_pulse    one-cycle error event per channel
//   all_locked   >=1 channel enabled and every enabled channel locked
//   fail_any     OR of ch_fail
//   results_cnt  saturating count of error events
//   state_dbg    per-channel FSM state, 3 bits per channel (channel c at [3c+:3])
//
// Control semantics: arm and clear are plain single-cycle request pulses with
// no acknowledge. Each is acted on at the clk_tb edge where it is sampled high.
// arm takes priority over every per-channel transition. A channel whose ch_en
// is low returns to IDLE on the next edge.
module pll_lock_monitor #(
  parameter int NUM_CH       = 3,
  parameter int SYNC_STAGES  = 3,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int MAX_RELOCK   = 1,
  parameter int ERR_CNT_W    = 3
) (
  input  logic                  clk_tb,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  clear,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic [NUM_CH-1:0]     pll_lock,
  output logic [NUM_CH-1:0]     ch_locked,
  output logic [NUM_CH-1:0]     ch_fail,
  output logic [NUM_CH-1:0]     err_pulse,
  output logic                  all_locked,
  output logic                  fail_any,
  output logic [ERR_CNT_W-1:0]  results_cnt,
  output logic [3*NUM_CH-1:0]   state_dbg
);

  localparam int TMR_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]       MAX_RL   = 2'(MAX_RELOCK);
  localparam logic [31:0]      CNT_MAX  = (32'd1 << ERR_CNT_W) - 32'd1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_LOCKED    = 3'd2,
    ST_LOST      = 3'd3,
    ST_FAIL      = 3'd4
  } ch_state_e;

  // Lock synchroniser: a plain flop chain per bit with no filtering.
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] lk;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pll_lock;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign lk = sync_q[SYNC_STAGES-1];

  // err_next is the registered pulse's next value. The error counter adds it
  // on the same edge, so results_cnt moves together with err_pulse.
  logic [NUM_CH-1:0] err_next;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]       rl_q, rl_d;
    logic             err_q, err_d;
    logic             timeout;

    assign timeout = (tmr_q == TMR_LAST);

    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      rl_d    = rl_q;
      err_d   = 1'b0;
      if (state_q == ST_WAIT_LOCK || state_q == ST_LOST) tmr_d = tmr_q + TMR_W'(1);

      if (arm) begin
        // arm overrides any pending transition and suppresses its pulse.
        tmr_d   = '0;
        rl_d    = '0;
        state_d = ch_en[c] ? ST_WAIT_LOCK : ST_IDLE;
      end else if (!ch_en[c]) begin
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_WAIT_LOCK: begin
            // Level check, so a PLL already locked at arm is accepted.
            // Lock wins over a timeout in the same cycle.
            if (lk[c]) begin
              state_d = ST_LOCKED;
            end else if (timeout) begin
              state_d = ST_FAIL;
              err_d   = 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!lk[c]) begin
              state_d = ST_LOST;
              err_d   = 1'b1;
              tmr_d   = '0;
              rl_d    = (rl_q == 2'd3) ? rl_q : rl_q + 2'd1;
            end
          end
          ST_LOST: begin
            // The loss was already reported, so a relock beyond the allowance
            // fails silently.
            if (lk[c]) begin
              state_d = (rl_q <= MAX_RL) ? ST_LOCKED : ST_FAIL;
            end else if (timeout) begin
              state_d = ST_FAIL;
              err_d   = 1'b1;
            end
          end
          ST_FAIL: ;
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        tmr_q   <= '0;
        rl_q    <= '0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
        rl_q    <= rl_d;
        err_q   <= err_d;
      end
    end

    assign ch_locked[c]       = (state_q == ST_LOCKED);
    assign ch_fail[c]         = (state_q == ST_FAIL);
    assign err_pulse[c]       = err_q;
    assign err_next[c]        = err_d;
    assign state_dbg[3*c +: 3] = state_q;
  end

  assign all_locked = (|ch_en) & (&(ch_locked | ~ch_en));
  assign fail_any   = |ch_fail;

  logic [31:0]          n_err;
  logic [31:0]          cnt_sum;
  logic [ERR_CNT_W-1:0] cnt_d;

  always_comb begin
    n_err = '0;
    for (int i = 0; i < NUM_CH; i++) n_err = n_err + {31'd0, err_next[i]};
    cnt_sum = 32'(results_cnt) + n_err;
    if (clear)                  cnt_d = '0;
    else if (cnt_sum > CNT_MAX) cnt_d = ERR_CNT_W'(CNT_MAX);
    else                        cnt_d = ERR_CNT_W'(cnt_sum);
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) results_cnt <= '0;
    else        results_cnt <= cnt_d;
  end

endmodule

// File: tb/tb_pll_lock_monitor.sv
`timescale 1ns/1ps
// tb_pll_lock_monitor
//   Self-checking bench for pll_lock_monitor with LOCK_TIMEOUT=64 and the
//   other parameters at their defaults. Each row of stimulus is applied for
//   'reps' clock cycles. Its expected output bundle is queued when the row is
//   driven, and popped and compared 1 ns after the following rising edge.
module tb_pll_lock_monitor;

  localparam int NUM_CH    = 3;
  localparam int ERR_CNT_W = 3;
  localparam int OUT_W     = 3*NUM_CH + 2 + ERR_CNT_W;

  // clock / reset / DUT
  logic                 clk_tb = 1'b0;
  logic                 rst_n  = 1'b0;
  logic                 arm    = 1'b0;
  logic                 clear  = 1'b0;
  logic [NUM_CH-1:0]    ch_en  = '0;
  logic [NUM_CH-1:0]    pll_lock = '0;
  logic [NUM_CH-1:0]    ch_locked, ch_fail, err_pulse;
  logic                 all_locked, fail_any;
  logic [ERR_CNT_W-1:0] results_cnt;
  logic [3*NUM_CH-1:0]  state_dbg;

  always #5 clk_tb = ~clk_tb;

  pll_lock_monitor #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(3), .LOCK_TIMEOUT(64),
    .MAX_RELOCK(1), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk_tb(clk_tb), .rst_n(rst_n), .arm(arm), .clear(clear),
    .ch_en(ch_en), .pll_lock(pll_lock),
    .ch_locked(ch_locked), .ch_fail(ch_fail), .err_pulse(err_pulse),
    .all_locked(all_locked), .fail_any(fail_any),
    .results_cnt(results_cnt), .state_dbg(state_dbg)
  );

  // vector records
  typedef struct {
    string      name;
    logic       arm;
    logic       clr;
    logic [2:0] en;
    logic [2:0] lock;
    int         reps;
    logic [2:0] locked;
    logic [2:0] fail;
    logic [2:0] err;
    logic       all;
    logic [2:0] cnt;
  } vec_t;

  function automatic vec_t mk(input string name, input logic a, input logic c,
                              input logic [2:0] en, input logic [2:0] lk, input int reps,
                              input logic [2:0] lkd, input logic [2:0] fl,
                              input logic [2:0] er, input logic al, input logic [2:0] cnt);
    vec_t v;
    v.name = name; v.arm = a; v.clr = c; v.en = en; v.lock = lk; v.reps = reps;
    v.locked = lkd; v.fail = fl; v.err = er; v.all = al; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] pack_exp(input vec_t v);
    return {v.locked, v.fail, v.err, v.all, |v.fail, v.cnt};
  endfunction

  // scoreboard
  logic [OUT_W-1:0] exp_q[$];
  string            name_q[$];
  int               vec_count   = 0;
  int               miscompares = 0;

  task automatic check_out();
    logic [OUT_W-1:0] got, exp_v;
    string            nm;
    got = {ch_locked, ch_fail, err_pulse, all_locked, fail_any, results_cnt};
    vec_count++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got %b, required a queued expectation", got);
      return;
    end
    exp_v = exp_q.pop_front();
    nm    = name_q.pop_front();
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got lock=%b fail=%b err=%b all=%b any=%b cnt=%0d, required lock=%b fail=%b err=%b all=%b any=%b cnt=%0d",
               nm, got[13:11], got[10:8], got[7:5], got[4], got[3], got[2:0],
               exp_v[13:11], exp_v[10:8], exp_v[7:5], exp_v[4], exp_v[3], exp_v[2:0]);
    end
  endtask

  // driver
  task automatic apply(input vec_t v);
    for (int r = 0; r < v.reps; r++) begin
      arm      = v.arm;
      clear    = v.clr;
      ch_en    = v.en;
      pll_lock = v.lock;
      exp_q.push_back(pack_exp(v));
      name_q.push_back(v.name);
      @(posedge clk_tb);
      #1;
      arm   = 1'b0;
      clear = 1'b0;
      check_out();
    end
  endtask

  vec_t tbl[$];

  initial begin
    int prev;
    int nxt;

    // Main table: ch0/ch2 lock, ch1 times out, ch2 loses lock twice.
    tbl.push_back(mk("arm",          1'b1, 1'b0, 3'd7, 3'd0,  1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));
    tbl.push_back(mk("lk0_sync",     1'b0, 1'b0, 3'd7, 3'd1,  3, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));
    tbl.push_back(mk("lk0_locked",   1'b0, 1'b0, 3'd7, 3'd1,  2, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0));
    tbl.push_back(mk("lk2_sync",     1'b0, 1'b0, 3'd7, 3'd5,  3, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0));
    tbl.push_back(mk("lk2_locked",   1'b0, 1'b0, 3'd7, 3'd5, 55, 3'd5, 3'd0, 3'd0, 1'b0, 3'd0));
    tbl.push_back(mk("ch1_timeout",  1'b0, 1'b0, 3'd7, 3'd5,  1, 3'd5, 3'd2, 3'd2, 1'b0, 3'd1));
    tbl.push_back(mk("ch1_fail",     1'b0, 1'b0, 3'd7, 3'd5,  1, 3'd5, 3'd2, 3'd0, 1'b0, 3'd1));
    tbl.push_back(mk("drop2_sync",   1'b0, 1'b0, 3'd7, 3'd1,  3, 3'd5, 3'd2, 3'd0, 1'b0, 3'd1));
    tbl.push_back(mk("drop2_err",    1'b0, 1'b0, 3'd7, 3'd1,  1, 3'd1, 3'd2, 3'd4, 1'b0, 3'd2));
    tbl.push_back(mk("drop2_lost",   1'b0, 1'b0, 3'd7, 3'd1,  6, 3'd1, 3'd2, 3'd0, 1'b0, 3'd2));
    tbl.push_back(mk("rest2_sync",   1'b0, 1'b0, 3'd7, 3'd5,  3, 3'd1, 3'd2, 3'd0, 1'b0, 3'd2));
    tbl.push_back(mk("relock2",      1'b0, 1'b0, 3'd7, 3'd5,  3, 3'd5, 3'd2, 3'd0, 1'b0, 3'd2));
    tbl.push_back(mk("drop2b_sync",  1'b0, 1'b0, 3'd7, 3'd1,  3, 3'd5, 3'd2, 3'd0, 1'b0, 3'd2));
    tbl.push_back(mk("drop2b_err",   1'b0, 1'b0, 3'd7, 3'd1,  1, 3'd1, 3'd2, 3'd4, 1'b0, 3'd3));
    tbl.push_back(mk("drop2b_lost",  1'b0, 1'b0, 3'd7, 3'd1,  6, 3'd1, 3'd2, 3'd0, 1'b0, 3'd3));
    tbl.push_back(mk("rest2b_sync",  1'b0, 1'b0, 3'd7, 3'd5,  3, 3'd1, 3'd2, 3'd0, 1'b0, 3'd3));
    tbl.push_back(mk("relock2_fail", 1'b0, 1'b0, 3'd7, 3'd5,  3, 3'd1, 3'd6, 3'd0, 1'b0, 3'd3));
    // Simultaneous loss on ch0 and ch1 after a re-arm with all PLLs locked.
    tbl.push_back(mk("preload",      1'b0, 1'b0, 3'd7, 3'd7,  3, 3'd1, 3'd6, 3'd0, 1'b0, 3'd3));
    tbl.push_back(mk("rearm",        1'b1, 1'b0, 3'd7, 3'd7,  1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd3));
    tbl.push_back(mk("relock_all",   1'b0, 1'b0, 3'd7, 3'd7,  3, 3'd7, 3'd0, 3'd0, 1'b1, 3'd3));
    tbl.push_back(mk("drop01_sync",  1'b0, 1'b0, 3'd7, 3'd4,  3, 3'd7, 3'd0, 3'd0, 1'b1, 3'd3));
    tbl.push_back(mk("drop01_err",   1'b0, 1'b0, 3'd7, 3'd4,  1, 3'd4, 3'd0, 3'd3, 1'b0, 3'd5));
    tbl.push_back(mk("drop01_lost",  1'b0, 1'b0, 3'd7, 3'd4,  1, 3'd4, 3'd0, 3'd0, 1'b0, 3'd5));
    // Relock, then disable ch1 while it is locked.
    tbl.push_back(mk("rest01_sync",  1'b0, 1'b0, 3'd7, 3'd7,  3, 3'd4, 3'd0, 3'd0, 1'b0, 3'd5));
    tbl.push_back(mk("relock01",     1'b0, 1'b0, 3'd7, 3'd7,  2, 3'd7, 3'd0, 3'd0, 1'b1, 3'd5));
    tbl.push_back(mk("dis1",         1'b0, 1'b0, 3'd5, 3'd7,  1, 3'd5, 3'd0, 3'd0, 1'b1, 3'd5));
    tbl.push_back(mk("dis1_unlk",    1'b0, 1'b0, 3'd5, 3'd5,  5, 3'd5, 3'd0, 3'd0, 1'b1, 3'd5));
    tbl.push_back(mk("idle_clr",     1'b0, 1'b1, 3'd0, 3'd0,  1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));
    tbl.push_back(mk("idle_sync",    1'b0, 1'b0, 3'd0, 3'd0,  3, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));

    // reset state
    ch_en = 3'd7;
    rst_n = 1'b0;
    #1;
    exp_q.push_back('0);
    name_q.push_back("reset_state");
    check_out();
    repeat (2) @(posedge clk_tb);
    #1;
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Saturation: three arms with every lock low give nine timeout events.
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      nxt = (prev + 3 > 7) ? 7 : prev + 3;
      apply(mk("sat_arm",  1'b1, 1'b0, 3'd7, 3'd0,  1, 3'd0, 3'd0, 3'd0, 1'b0, 3'(prev)));
      apply(mk("sat_wait", 1'b0, 1'b0, 3'd7, 3'd0, 63, 3'd0, 3'd0, 3'd0, 1'b0, 3'(prev)));
      apply(mk("sat_tmo",  1'b0, 1'b0, 3'd7, 3'd0,  1, 3'd0, 3'd7, 3'd7, 1'b0, 3'(nxt)));
      apply(mk("sat_fail", 1'b0, 1'b0, 3'd7, 3'd0,  1, 3'd0, 3'd7, 3'd0, 1'b0, 3'(nxt)));
      prev = nxt;
    end

    // clear coinciding with a timeout event
    apply(mk("clr_arm",   1'b1, 1'b0, 3'd7, 3'd0,  1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd7));
    apply(mk("clr_wait",  1'b0, 1'b0, 3'd7, 3'd0, 63, 3'd0, 3'd0, 3'd0, 1'b0, 3'd7));
    apply(mk("clr_tmo",   1'b0, 1'b1, 3'd7, 3'd0,  1, 3'd0, 3'd7, 3'd7, 1'b0, 3'd0));
    apply(mk("clr_after", 1'b0, 1'b0, 3'd7, 3'd0,  1, 3'd0, 3'd7, 3'd0, 1'b0, 3'd0));

    // arm on the timeout cycle suppresses the pulse; lock then wins on the last cycle
    apply(mk("pend_arm",   1'b1, 1'b0, 3'd7, 3'd0,  1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));
    apply(mk("pend_wait",  1'b0, 1'b0, 3'd7, 3'd0, 63, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));
    apply(mk("arm_on_tmo", 1'b1, 1'b0, 3'd7, 3'd0,  1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));
    apply(mk("wait2",      1'b0, 1'b0, 3'd7, 3'd0, 60, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));
    apply(mk("late_lk",    1'b0, 1'b0, 3'd7, 3'd7,  3, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));
    apply(mk("lock_wins",  1'b0, 1'b0, 3'd7, 3'd7,  1, 3'd7, 3'd0, 3'd0, 1'b1, 3'd0));

    // asynchronous reset in the middle of WAIT_LOCK
    apply(mk("dropall_sync", 1'b0, 1'b0, 3'd7, 3'd0, 3, 3'd7, 3'd0, 3'd0, 1'b1, 3'd0));
    apply(mk("dropall_err",  1'b0, 1'b0, 3'd7, 3'd0, 1, 3'd0, 3'd0, 3'd7, 1'b0, 3'd3));
    apply(mk("dropall_lost", 1'b0, 1'b0, 3'd7, 3'd0, 1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd3));
    apply(mk("rst_arm",      1'b1, 1'b0, 3'd7, 3'd0, 1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd3));
    apply(mk("rst_wait",     1'b0, 1'b0, 3'd7, 3'd0, 2, 3'd0, 3'd0, 3'd0, 1'b0, 3'd3));
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back('0);
    name_q.push_back("async_reset");
    check_out();
    apply(mk("in_reset",  1'b0, 1'b0, 3'd7, 3'd0, 2, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));
    rst_n = 1'b1;
    apply(mk("post_rst",  1'b0, 1'b0, 3'd7, 3'd0, 2, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));
    apply(mk("post_arm",  1'b1, 1'b0, 3'd7, 3'd7, 1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));
    apply(mk("post_sync", 1'b0, 1'b0, 3'd7, 3'd7, 2, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0));
    apply(mk("post_lock", 1'b0, 1'b0, 3'd7, 3'd7, 1, 3'd7, 3'd0, 3'd0, 1'b1, 3'd0));

    // final report
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_residue: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
